// File: rtl/inert_intf.sv
// Inertial sensor front end: configures the IMU over SPI, then reads
// pitch rate and Z acceleration bytes on every data-ready interrupt.
module inert_intf #(
  parameter int INIT_WAIT_BITS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic [15:0] ptch_rt,
  output logic [15:0] AZ,
  output logic        vld
);

  typedef enum logic [3:0] {
    INIT_WAIT,
    INIT1,
    INIT2,
    INIT3,
    INIT4,
    WAIT_INT,
    RD_PL,
    RD_PH,
    RD_AL,
    RD_AH
  } state_t;

  state_t state, nxt;

  logic [INIT_WAIT_BITS-1:0] cnt;
  logic int_s1, int_s2;

  logic        wrt_nxt;
  logic [15:0] cmd_nxt;
  logic        vld_nxt;
  logic [3:0]  cap;

  logic [7:0] ptch_l, ptch_h, az_l, az_h;

  logic unused_rd_hi;
  assign unused_rd_hi = ^rd_data[15:8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_s1 <= 1'b0;
      int_s2 <= 1'b0;
    end else begin
      int_s1 <= INT;
      int_s2 <= int_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else
      cnt <= cnt + {{(INIT_WAIT_BITS-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT_WAIT;
      wrt   <= 1'b0;
      cmd   <= 16'h0000;
      vld   <= 1'b0;
    end else begin
      state <= nxt;
      wrt   <= wrt_nxt;
      cmd   <= cmd_nxt;
      vld   <= vld_nxt;
    end
  end

  always_comb begin
    nxt     = state;
    wrt_nxt = 1'b0;
    cmd_nxt = cmd;
    vld_nxt = 1'b0;
    cap     = 4'b0000;
    unique case (state)
      INIT_WAIT:
        if (&cnt) begin
          wrt_nxt = 1'b1;
          cmd_nxt = 16'h0D02;
          nxt     = INIT1;
        end
      INIT1:
        if (done) begin
          wrt_nxt = 1'b1;
          cmd_nxt = 16'h1053;
          nxt     = INIT2;
        end
      INIT2:
        if (done) begin
          wrt_nxt = 1'b1;
          cmd_nxt = 16'h1150;
          nxt     = INIT3;
        end
      INIT3:
        if (done) begin
          wrt_nxt = 1'b1;
          cmd_nxt = 16'h1460;
          nxt     = INIT4;
        end
      INIT4:
        if (done)
          nxt = WAIT_INT;
      WAIT_INT:
        if (int_s2) begin
          wrt_nxt = 1'b1;
          cmd_nxt = 16'hA200;
          nxt     = RD_PL;
        end
      RD_PL:
        if (done) begin
          cap[0]  = 1'b1;
          wrt_nxt = 1'b1;
          cmd_nxt = 16'hA300;
          nxt     = RD_PH;
        end
      RD_PH:
        if (done) begin
          cap[1]  = 1'b1;
          wrt_nxt = 1'b1;
          cmd_nxt = 16'hAC00;
          nxt     = RD_AL;
        end
      RD_AL:
        if (done) begin
          cap[2]  = 1'b1;
          wrt_nxt = 1'b1;
          cmd_nxt = 16'hAD00;
          nxt     = RD_AH;
        end
      RD_AH:
        if (done) begin
          cap[3]  = 1'b1;
          vld_nxt = 1'b1;
          nxt     = WAIT_INT;
        end
      default:
        nxt = INIT_WAIT;
    endcase
  end

  // Capture lands on the same edge vld rises, so the pair is coherent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptch_l <= 8'h00;
      ptch_h <= 8'h00;
      az_l   <= 8'h00;
      az_h   <= 8'h00;
    end else begin
      if (cap[0]) ptch_l <= rd_data[7:0];
      if (cap[1]) ptch_h <= rd_data[7:0];
      if (cap[2]) az_l   <= rd_data[7:0];
      if (cap[3]) az_h   <= rd_data[7:0];
    end
  end

  assign ptch_rt = {ptch_h, ptch_l};
  assign AZ      = {az_h, az_l};

endmodule

// File: tb/tb_inert_intf.sv
// Directed bench for inert_intf: init sequence, reads, INT corner cases,
// spurious done and mid-read reset.
module tb_inert_intf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        INT;
  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] rd_data;
  logic [15:0] ptch_rt;
  logic [15:0] AZ;
  logic        vld;

  int checks = 0;
  int errors = 0;
  int vcnt = 0;
  int ovl = 0;
  bit outst = 1'b0;

  inert_intf #(.INIT_WAIT_BITS(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .INT     (INT),
    .wrt     (wrt),
    .cmd     (cmd),
    .done    (done),
    .rd_data (rd_data),
    .ptch_rt (ptch_rt),
    .AZ      (AZ),
    .vld     (vld)
  );

  always #5 clk = ~clk;

  // Tracks outstanding transactions and vld pulses.
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      outst = 1'b0;
    end else begin
      if (done) outst = 1'b0;
      if (wrt) begin
        if (outst) ovl++;
        outst = 1'b1;
      end
      if (vld) vcnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_wrt(input string tag, input logic [15:0] exp,
                          output int n);
    n = 0;
    while (wrt !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_wrt"}, {31'd0, wrt}, 32'd1);
    chk({tag, "_cmd"}, {16'd0, cmd}, {16'd0, exp});
  endtask

  task automatic do_done(input logic [7:0] d);
    done    = 1'b1;
    rd_data = {8'hE5, d};
    @(negedge clk);
    done    = 1'b0;
    rd_data = 16'h0000;
  endtask

  task automatic txn(input string tag, input logic [15:0] exp,
                     input logic [7:0] d, input int gap);
    int n;
    bit bad;
    wait_wrt(tag, exp, n);
    bad = 1'b0;
    repeat (gap) begin
      @(negedge clk);
      if (wrt !== 1'b0 || cmd !== exp) bad = 1'b1;
    end
    chk({tag, "_hold"}, {31'd0, bad}, 32'd0);
    do_done(d);
  endtask

  task automatic quiet(input string tag, input int cyc);
    bit bad;
    bad = 1'b0;
    repeat (cyc) begin
      @(negedge clk);
      if (wrt !== 1'b0 || vld !== 1'b0) bad = 1'b1;
    end
    chk(tag, {31'd0, bad}, 32'd0);
  endtask

  task automatic init_seq(input string tag);
    int n;
    wait_wrt({tag, "_first"}, 16'h0D02, n);
    chk({tag, "_lat"}, n, 32'd16);
    txn({tag, "0"}, 16'h0D02, 8'h00, 3);
    txn({tag, "1"}, 16'h1053, 8'h00, 2);
    txn({tag, "2"}, 16'h1150, 8'h00, 4);
    txn({tag, "3"}, 16'h1460, 8'h00, 2);
    quiet({tag, "_idle"}, 6);
  endtask

  task automatic rd_seq(input string tag, input logic [7:0] pl,
                        input logic [7:0] ph, input logic [7:0] al,
                        input logic [7:0] ah);
    txn({tag, "_pl"}, 16'hA200, pl, 2);
    txn({tag, "_ph"}, 16'hA300, ph, 3);
    txn({tag, "_al"}, 16'hAC00, al, 2);
    txn({tag, "_ah"}, 16'hAD00, ah, 3);
    chk({tag, "_vld"}, {31'd0, vld}, 32'd1);
    chk({tag, "_ptch"}, {16'd0, ptch_rt}, {16'd0, ph, pl});
    chk({tag, "_az"}, {16'd0, AZ}, {16'd0, ah, al});
  endtask

  initial begin
    int n;
    int v0;
    rst_n   = 1'b0;
    INT     = 1'b0;
    done    = 1'b0;
    rd_data = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_wrt", {31'd0, wrt}, 32'd0);
    chk("rst_cmd", {16'd0, cmd}, 32'd0);
    chk("rst_vld", {31'd0, vld}, 32'd0);
    chk("rst_ptch", {16'd0, ptch_rt}, 32'd0);
    chk("rst_az", {16'd0, AZ}, 32'd0);
    rst_n = 1'b1;
    init_seq("init");

    // Single read
    v0  = vcnt;
    INT = 1'b1;
    wait_wrt("r1_start", 16'hA200, n);
    chk("r1_lat", n, 32'd3);
    INT = 1'b0;
    rd_seq("r1", 8'h34, 8'h12, 8'hCD, 8'hAB);
    @(negedge clk);
    chk("r1_vld_1cyc", {31'd0, vld}, 32'd0);
    quiet("r1_after", 8);
    chk("r1_vcnt", vcnt, v0 + 1);

    // INT held high: back-to-back sequences
    v0  = vcnt;
    INT = 1'b1;
    rd_seq("r2", 8'h11, 8'h22, 8'h33, 8'h44);
    chk("r2_nowrt", {31'd0, wrt}, 32'd0);
    wait_wrt("r3_start", 16'hA200, n);
    chk("r3_lat", n, 32'd1);
    INT = 1'b0;
    rd_seq("r3", 8'h55, 8'h66, 8'h77, 8'h88);
    quiet("r3_after", 8);
    chk("r23_vcnt", vcnt, v0 + 2);
    chk("r23_ovl", ovl, 32'd0);

    // INT pulse while in RD_PH
    v0  = vcnt;
    INT = 1'b1;
    wait_wrt("r4_start", 16'hA200, n);
    INT = 1'b0;
    txn("r4_pl", 16'hA200, 8'h78, 4);
    wait_wrt("r4_ph", 16'hA300, n);
    @(negedge clk);
    INT = 1'b1;
    repeat (2) @(negedge clk);
    INT = 1'b0;
    do_done(8'h56);
    txn("r4_al", 16'hAC00, 8'h21, 3);
    txn("r4_ah", 16'hAD00, 8'h43, 2);
    chk("r4_ptch", {16'd0, ptch_rt}, 32'h5678);
    chk("r4_az", {16'd0, AZ}, 32'h4321);
    quiet("r4_after", 10);
    chk("r4_vcnt", vcnt, v0 + 1);

    // Spurious done in WAIT_INT
    do_done(8'hFF);
    quiet("sp_quiet", 6);
    chk("sp_ptch", {16'd0, ptch_rt}, 32'h5678);
    chk("sp_az", {16'd0, AZ}, 32'h4321);

    // Reset during RD_AL
    v0  = vcnt;
    INT = 1'b1;
    wait_wrt("r5_start", 16'hA200, n);
    INT = 1'b0;
    txn("r5_pl", 16'hA200, 8'h9A, 2);
    txn("r5_ph", 16'hA300, 8'hBC, 2);
    wait_wrt("r5_al", 16'hAC00, n);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mr_ptch", {16'd0, ptch_rt}, 32'd0);
    chk("mr_az", {16'd0, AZ}, 32'd0);
    chk("mr_wrt", {31'd0, wrt}, 32'd0);
    chk("mr_cmd", {16'd0, cmd}, 32'd0);
    chk("mr_vld", {31'd0, vld}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    init_seq("reinit");
    chk("mr_vcnt", vcnt, v0);

    // Normal operation after re-init
    INT = 1'b1;
    wait_wrt("r6_start", 16'hA200, n);
    INT = 1'b0;
    rd_seq("r6", 8'h01, 8'h02, 8'h03, 8'h04);
    quiet("r6_after", 6);
    chk("end_ovl", ovl, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inert_intf.md
INERT_INTF -- requirements
Module: inert_intf

Interface
REQ-001 SHALL have parameter: INIT_WAIT_BITS, 16, width of the power-up wait counter (reduced in simulation).
REQ-002 SHALL have port: clk  input  1  system clock.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: INT  input  1  IMU data-ready interrupt; asynchronous, active-high.
REQ-005 SHALL have port: wrt  output  1  one-cycle strobe starting an SPI transaction on the SPI master.
REQ-006 SHALL have port: cmd  output  16  SPI command word, {addr/rw byte, data byte}.
REQ-007 SHALL have port: done  input  1  one-cycle pulse from the SPI master at transaction end.
REQ-008 SHALL have port: rd_data  input  16  SPI master receive word; only [7:0] is used.
REQ-009 SHALL have port: ptch_rt  output  16  signed pitch rate, {high byte, low byte}.
REQ-010 SHALL have port: AZ  output  16  signed Z acceleration, {high byte, low byte}.
REQ-011 SHALL have port: vld  output  1  one-cycle pulse; ptch_rt and AZ hold a new, coherent sample.

Function
REQ-012 INT SHALL pass through a 2-flop synchronizer; the FSM SHALL use only the second flop.
REQ-013 A free-running INIT_WAIT_BITS counter SHALL run from reset; leave INIT_WAIT only when the counter is all ones.
REQ-014 FSM states SHALL be: INIT_WAIT, INIT1, INIT2, INIT3, INIT4, WAIT_INT, RD_PL, RD_PH, RD_AL, RD_AH.
REQ-015 On leaving INIT_WAIT, SHALL pulse wrt with cmd=16'h0D02 (data-ready INT enable) and enter INIT1.
REQ-016 On each done in INIT1/INIT2/INIT3, SHALL pulse wrt with cmd 16'h1053 (accel 208 Hz), 16'h1150 (gyro 208 Hz), 16'h1460 (rounding) respectively and advance one state.
REQ-017 On done in INIT4, SHALL enter WAIT_INT with no wrt.
REQ-018 In WAIT_INT, synced INT high SHALL pulse wrt with cmd=16'hA200 and enter RD_PL.
REQ-019 On done in RD_PL/RD_PH/RD_AL, SHALL capture rd_data[7:0] into ptch_L/ptch_H/AZ_L, pulse wrt with cmd 16'hA300/16'hAC00/16'hAD00, and advance.
REQ-020 On done in RD_AH, SHALL capture rd_data[7:0] into AZ_H, return to WAIT_INT.
REQ-021 vld SHALL pulse high for exactly the cycle after the RD_AH done.
REQ-022 ptch_rt and AZ SHALL be driven continuously from the four byte registers: {ptch_H,ptch_L} and {AZ_H,AZ_L}.
REQ-023 Only one transaction SHALL be outstanding; wrt SHALL never assert before done of the previous command.
REQ-024 wrt SHALL be registered, high exactly one cycle per command; cmd SHALL be registered and stable from wrt until done.
REQ-025 done in INIT_WAIT or WAIT_INT SHALL be ignored.
REQ-026 INT activity outside WAIT_INT SHALL be ignored, not queued; INT still high on return to WAIT_INT SHALL start a new read sequence the next cycle.
REQ-027 Latency from INT rising to vld: 2 synchronizer cycles + 1 cycle + four SPI transactions + 1 cycle.

Reset
REQ-028 SHALL, on rst_n low, asynchronously clear state to INIT_WAIT, counter, synchronizer, wrt, vld, cmd, and all byte registers; ptch_rt=0, AZ=0.
REQ-029 Reset mid-transaction SHALL abandon the sequence; the init sequence SHALL re-run in full after deassertion.

Verification
REQ-030 Bench SHALL cover: INIT_WAIT_BITS=4, reset release -> first wrt 16 cycles later with cmd=0D02, then 1053, 1150, 1460, one wrt per done, none before done.
REQ-031 Bench SHALL cover: after init, INT high, rd_data bytes 34,12,CD,AB -> cmds A200,A300,AC00,AD00, ptch_rt=16'h1234, AZ=16'hABCD, vld pulses one cycle.
REQ-032 Bench SHALL cover: INT held high permanently -> back-to-back read sequences, one vld per sequence, no wrt overlap.
REQ-033 Bench SHALL cover: INT pulse during RD_PH -> no extra sequence, single vld.
REQ-034 Bench SHALL cover: spurious done in WAIT_INT -> no wrt, no state change, ptch_rt/AZ unchanged.
REQ-035 Bench SHALL cover: rst_n low during RD_AL -> outputs 0, vld stays 0, init cmds replayed starting with 0D02.
